// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester (IF/ME) arbiter onto a single non-pipelined memory port
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [63:0] if_addr,
    input  logic [1:0]  if_size,
    output logic        if_ready,
    output logic [63:0] if_rdata,
    output logic [1:0]  if_resp,
    input  logic        me_valid,
    input  logic        me_req,
    input  logic [63:0] me_addr,
    input  logic [63:0] me_wdata,
    input  logic [1:0]  me_size,
    output logic        me_ready,
    output logic [63:0] me_rdata,
    output logic [1:0]  me_resp,
    output logic        bus_valid,
    output logic        bus_req,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [1:0]  bus_size,
    input  logic        bus_ready,
    input  logic [63:0] bus_rdata,
    input  logic [1:0]  bus_resp,
    output logic        busy
);
    localparam logic             REQ_READ = 1'b0;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_ME, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic             owner_me;
    logic [CNT_W-1:0] streak;
    logic             grant_if;
    logic             grant_me;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ME wins contested arbitration unless IF has been passed over STARVE_LIMIT times
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_me   = 1'b0;
        case (state)
            IDLE: begin
                if (if_valid && (!me_valid || streak == LIMIT)) begin
                    grant_if   = 1'b1;
                    state_next = BUS_IF;
                end else if (me_valid) begin
                    grant_me   = 1'b1;
                    state_next = BUS_ME;
                end
            end
            BUS_IF, BUS_ME: begin
                if (bus_ready) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_me  <= 1'b0;
            streak    <= '0;
            bus_valid <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_size  <= '0;
            if_rdata  <= '0;
            if_resp   <= '0;
            me_rdata  <= '0;
            me_resp   <= '0;
        end else begin
            if (grant_if) begin
                owner_me  <= 1'b0;
                streak    <= '0;
                bus_valid <= 1'b1;
                bus_req   <= REQ_READ;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_size  <= if_size;
            end else if (grant_me) begin
                owner_me  <= 1'b1;
                if (!if_valid) begin
                    streak <= '0;
                end else if (streak != LIMIT) begin
                    streak <= streak + CNT_W'(1);
                end
                bus_valid <= 1'b1;
                bus_req   <= me_req;
                bus_addr  <= me_addr;
                bus_wdata <= me_wdata;
                bus_size  <= me_size;
            end
            // Capture happens even for an orphaned owner; only the ready pulse is suppressed
            if ((state == BUS_IF || state == BUS_ME) && bus_ready) begin
                bus_valid <= 1'b0;
                if (owner_me) begin
                    me_rdata <= bus_rdata;
                    me_resp  <= bus_resp;
                end else begin
                    if_rdata <= bus_rdata;
                    if_resp  <= bus_resp;
                end
            end
        end
    end

    assign if_ready = (state == RESP) && !owner_me && if_valid;
    assign me_ready = (state == RESP) && owner_me && me_valid;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [63:0] if_addr;
    logic [1:0]  if_size;
    logic        if_ready;
    logic [63:0] if_rdata;
    logic [1:0]  if_resp;
    logic        me_valid;
    logic        me_req;
    logic [63:0] me_addr;
    logic [63:0] me_wdata;
    logic [1:0]  me_size;
    logic        me_ready;
    logic [63:0] me_rdata;
    logic [1:0]  me_resp;
    logic        bus_valid;
    logic        bus_req;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_ready;
    logic [63:0] bus_rdata;
    logic [1:0]  bus_resp;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_resp(if_resp),
        .me_valid(me_valid), .me_req(me_req), .me_addr(me_addr),
        .me_wdata(me_wdata), .me_size(me_size),
        .me_ready(me_ready), .me_rdata(me_rdata), .me_resp(me_resp),
        .bus_valid(bus_valid), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_size(bus_size),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_resp(bus_resp),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    localparam logic [63:0] IF_A = 64'h8000_0000;
    localparam logic [63:0] ME_A = 64'h100;

    bit   ok;
    logic owner_me;
    logic exp_me [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        reset_n   = 1'b0;
        if_valid  = 1'b0; if_addr = '0; if_size = '0;
        me_valid  = 1'b0; me_req = 1'b0; me_addr = '0; me_wdata = '0; me_size = '0;
        bus_ready = 1'b0; bus_rdata = '0; bus_resp = '0;
        #12;
        check_eq("rst_bus_valid", bus_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", {if_ready, me_ready}, 0);
        check_eq("rst_rdata", if_rdata | me_rdata, 0);
        reset_n = 1'b1;
        step();

        // IF-only read, bus_ready three cycles after bus_valid
        if_valid = 1'b1; if_addr = IF_A; if_size = 2'd2;
        step();
        check_eq("if_bus_valid_c1", bus_valid, 1);
        check_eq("if_bus_req", bus_req, 0);
        check_eq("if_bus_addr", bus_addr, IF_A);
        check_eq("if_bus_size", bus_size, 2);
        step(); step();
        check_eq("if_bus_valid_held", bus_valid, 1);
        step();
        bus_ready = 1'b1; bus_rdata = 64'h1234; bus_resp = 2'd1;
        step();
        bus_ready = 1'b0;
        check_eq("if_ready_c5", if_ready, 1);
        check_eq("if_rdata", if_rdata, 64'h1234);
        check_eq("if_resp", if_resp, 1);
        check_eq("if_me_ready_quiet", me_ready, 0);
        check_eq("if_bus_valid_drop", bus_valid, 0);
        step();
        if_valid = 1'b0;
        check_eq("if_ready_one_pulse", if_ready, 0);
        check_eq("if_idle", busy, 0);
        step();

        // Simultaneous IF read and ME write: ME first, IF right after
        if_valid = 1'b1; if_addr = 64'h40;
        me_valid = 1'b1; me_req = 1'b1; me_addr = ME_A; me_wdata = 64'hDEAD; me_size = 2'd3;
        step();
        check_eq("both_me_req", bus_req, 1);
        check_eq("both_me_wdata", bus_wdata, 64'hDEAD);
        check_eq("both_me_addr", bus_addr, ME_A);
        bus_ready = 1'b1; bus_rdata = 64'h0; bus_resp = 2'd0;
        step();
        bus_ready = 1'b0;
        check_eq("both_me_ready", me_ready, 1);
        check_eq("both_if_not_ready", if_ready, 0);
        step();
        me_valid = 1'b0;
        check_eq("both_idle_gap", bus_valid, 0);
        step();
        check_eq("both_if_grant", bus_valid, 1);
        check_eq("both_if_addr", bus_addr, 64'h40);
        check_eq("both_if_wdata", bus_wdata, 0);
        check_eq("both_if_req", bus_req, 0);
        bus_ready = 1'b1; bus_rdata = 64'h55;
        step();
        bus_ready = 1'b0;
        check_eq("both_if_ready", if_ready, 1);
        step();
        if_valid = 1'b0;
        step();

        // Starvation: ME held valid continuously while IF waits
        if_valid = 1'b1; if_addr = IF_A;
        me_valid = 1'b1; me_req = 1'b0; me_addr = ME_A;
        for (int g = 0; g < 6; g++) begin
            wait_grant(ok);
            check_eq($sformatf("starve_grant_ok%0d", g), ok, 1);
            owner_me = (bus_addr == ME_A);
            check_eq($sformatf("starve_owner%0d", g), owner_me, exp_me[g]);
            bus_ready = 1'b1; bus_rdata = 64'(g);
            step();
            bus_ready = 1'b0;
            if (exp_me[g]) check_eq($sformatf("starve_me_ready%0d", g), me_ready, 1);
            else           check_eq($sformatf("starve_if_ready%0d", g), if_ready, 1);
            if (g == 5) begin
                if_valid = 1'b0;
                me_valid = 1'b0;
            end
            step();
        end
        check_eq("starve_me_rdata", me_rdata, 5);
        check_eq("starve_if_rdata", if_rdata, 4);
        step();

        // Orphan: ME drops valid while its transaction is in flight
        me_valid = 1'b1; me_addr = 64'h200; me_req = 1'b0;
        step();
        check_eq("orph_grant", bus_valid, 1);
        me_valid = 1'b0;
        step();
        bus_ready = 1'b1; bus_rdata = 64'hBEEF; bus_resp = 2'd2;
        step();
        bus_ready = 1'b0;
        check_eq("orph_no_ready", me_ready, 0);
        check_eq("orph_rdata", me_rdata, 64'hBEEF);
        check_eq("orph_resp", me_resp, 2);
        check_eq("orph_busy_resp", busy, 1);
        step();
        check_eq("orph_busy_fall", busy, 0);
        if_valid = 1'b1; if_addr = 64'h300;
        step();
        check_eq("orph_next_grant", bus_valid, 1);
        check_eq("orph_next_addr", bus_addr, 64'h300);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check_eq("orph_next_ready", if_ready, 1);
        step();
        if_valid = 1'b0;
        step();

        // Asynchronous reset while in BUS_ME
        me_valid = 1'b1; me_addr = 64'h400;
        step();
        check_eq("rst_mid_bus_valid", bus_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_bus_valid", bus_valid, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_addr", bus_addr, 0);
        check_eq("rst_async_me_rdata", me_rdata, 0);
        me_valid = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
        bus_ready = 1'b1; bus_rdata = 64'h77;
        step();
        bus_ready = 1'b0;
        check_eq("rst_late_ready", {if_ready, me_ready}, 0);
        check_eq("rst_late_busy", busy, 0);
        step();
        check_eq("rst_late_ready2", {if_ready, me_ready}, 0);
        check_eq("rst_late_rdata", me_rdata, 0);

        // bus_ready in IDLE with no requests is ignored
        bus_ready = 1'b1; bus_rdata = 64'h99; bus_resp = 2'd3;
        step();
        bus_ready = 1'b0;
        check_eq("idle_ready_busy", busy, 0);
        check_eq("idle_ready_bus_valid", bus_valid, 0);
        check_eq("idle_ready_pulses", {if_ready, me_ready}, 0);
        check_eq("idle_ready_if_rdata", if_rdata, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single downstream memory port (toward the AXI bridge) between two requesters: instruction fetch (IF, read-only) and the memory stage (ME, read/write).
- Both requesters use the same valid/ready/req/size handshake.
- Registered, non-pipelined: one transaction in flight at a time.
- ME has priority, bounded by an anti-starvation counter for IF.

Parameters:
- STARVE_LIMIT, 4: consecutive ME grants taken while IF waits, after which IF wins the next contested arbitration.
- CNT_W, 3: width of the streak counter; must hold STARVE_LIMIT.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_valid  in  1  IF request pending
- if_addr  in  64  IF address
- if_size  in  2  IF size (SIZE_B/H/W/D encoding)
- if_ready  out  1  one-cycle completion pulse to IF
- if_rdata  out  64  IF read data, valid with if_ready
- if_resp  out  2  IF response, valid with if_ready
- me_valid  in  1  ME request pending
- me_req  in  1  REQ_READ=0 / REQ_WRITE=1
- me_addr  in  64  ME address
- me_wdata  in  64  ME write data
- me_size  in  2  ME size
- me_ready  out  1  one-cycle completion pulse to ME
- me_rdata  out  64  ME read data, valid with me_ready
- me_resp  out  2  ME response, valid with me_ready
- bus_valid  out  1  downstream request
- bus_req  out  1  downstream read/write
- bus_addr  out  64  downstream address
- bus_wdata  out  64  downstream write data
- bus_size  out  2  downstream size
- bus_ready  in  1  one-cycle downstream completion
- bus_rdata  in  64  downstream read data, valid with bus_ready
- bus_resp  in  2  downstream response, valid with bus_ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous on reset_n low.
  - State IDLE, streak counter 0.
  - All outputs 0, including rdata/resp registers.
  - Any in-flight downstream transaction is abandoned; no ready pulse is issued after reset releases.
- States: IDLE, BUS_IF, BUS_ME, RESP.
- IDLE, arbitration each cycle:
  - Only if_valid: go to BUS_IF.
  - Only me_valid: go to BUS_ME.
  - Both valid: BUS_IF if streak == STARVE_LIMIT, else BUS_ME.
  - Neither valid: stay in IDLE.
  - On the transition, latch addr/size/req/wdata into bus registers. For IF, bus_req = REQ_READ and bus_wdata = 0.
- Streak counter (updated at arbitration):
  - Increments on an ME grant while if_valid = 1, saturating at STARVE_LIMIT.
  - Clears on an IF grant, or on an ME grant with if_valid = 0.
- BUS_IF / BUS_ME:
  - bus_valid = 1 (registered, first asserted the cycle after arbitration).
  - bus_* are held stable until bus_ready.
  - On bus_ready: capture bus_rdata and bus_resp into the owner's rdata/resp registers, drop bus_valid, go to RESP. Exactly one handshake per grant.
- RESP: for one cycle, pulse the owner's ready, then go to IDLE. No arbitration occurs in RESP, so a requester still holding valid on its ready cycle is not re-issued.
- Latency:
  - Requester valid at cycle 0 gives bus_valid at cycle 1.
  - bus_ready at cycle k gives requester ready at cycle k+1.
  - Earliest next grant is at cycle k+2.
- Orphan transaction: if the owner drops valid after grant (e.g. ME exception flush), the downstream transaction still completes. Its ready pulse is suppressed if the owner's valid is 0 during RESP; rdata/resp registers still update.
- rdata/resp hold their last captured value between transactions.
- Requesters must keep addr/size/req/wdata stable only until the grant (values are latched). Valid may drop before grant, which withdraws the request without effect.
- bus_ready received while not in BUS_IF/BUS_ME is ignored.

Test Plan:
- IF only, if_addr=0x8000_0000, size SIZE_W, bus_ready 3 cycles after bus_valid, bus_rdata=0x1234 -> bus_valid at cycle 1, bus_req=0, if_ready pulse at cycle 5 with if_rdata=0x1234; me_ready stays 0.
- IF and ME valid together from the same cycle, ME write 0xDEAD to 0x100 -> ME granted first with bus_req=1, bus_wdata=0xDEAD; IF granted in the IDLE cycle after ME's RESP.
- Starvation: if_valid held, me_valid re-asserted continuously, STARVE_LIMIT=4 -> grant order ME,ME,ME,ME,IF, counter returns to 0.
- Orphan: ME granted, me_valid dropped while in BUS_ME, bus_ready later -> no me_ready pulse, me_rdata updated, busy falls, next grant proceeds normally.
- reset_n asserted in BUS_ME with bus_valid=1 -> all outputs 0 immediately (asynchronous); after release, a late bus_ready pulse produces no requester ready.
- bus_ready pulsed in IDLE with no requests -> no state change, no ready pulses.
